divider_8by4_shift_sub: RTL
===========================

# divider_8by4_shift_sub

Sequential restoring (shift-subtract) unsigned divider: divides a DIVIDEND_W-bit dividend by a DIVISOR_W-bit divisor, producing quotient and remainder. It is the inverse operation to the 4x4 shift-add multiplier and sits in the lecture arithmetic datapath. Over a start/busy/done handshake, an 8-bit product can be divided back by one 4-bit factor. Division takes one iteration per dividend bit.

## Interface
- DIVIDEND_W, 8, dividend and quotient width.
- DIVISOR_W, 4, divisor and remainder width.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request. Sampled on a rising clk edge; accepted only in IDLE or DONE.
- dividend  input  DIVIDEND_W  unsigned dividend, captured when start is accepted.
- divisor  input  DIVISOR_W  unsigned divisor, captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse. Results are valid from this cycle onward.
- quotient  output  DIVIDEND_W  unsigned quotient.
- remainder  output  DIVISOR_W  unsigned remainder.
- div_by_zero  output  1  set with done when the captured divisor was 0. Held with the results.

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: iterating.
  - DONE: results presented.
- IDLE/DONE with start=1:
  - Latch the divisor.
  - Load the shift register Q with the dividend.
  - Clear the partial remainder R (DIVISOR_W+1 bits).
  - Clear the bit counter.
  - Clear div_by_zero.
  - Divisor ≠ 0: go to RUN.
  - Divisor = 0: go directly to DONE with quotient = all-ones, remainder = 0, div_by_zero = 1.
- DONE with start=0: go to IDLE.
- RUN, each cycle, one restoring step:
  - Shift {R,Q} left by 1.
  - If R ≥ divisor: R ← R − divisor and Q[0] ← 1. Otherwise Q[0] ← 0.
  - Compare is unsigned at DIVISOR_W+1 bits.
  - Increment the counter.
  - After the DIVIDEND_W-th step, go to DONE.
- Outputs:
  - quotient = Q.
  - remainder = R[DIVISOR_W-1:0]. R never exceeds divisor−1 after a step.
- quotient/remainder/div_by_zero hold their last result until the next accepted start, including through IDLE.
- Only the final value in DONE is meaningful. Intermediate values during RUN are not defined for consumers.
- start while busy is ignored. The operands in flight are unaffected.
- Invariant on completion: dividend = quotient × divisor + remainder, and remainder < divisor.

## Timing
- Reset (rst_n low, asynchronous, any state, including mid-RUN):
  - State goes to IDLE immediately.
  - busy=0, done=0, div_by_zero=0.
  - quotient=0, remainder=0, counter=0.
  - No done pulse is produced for an aborted operation.
- Start accepted at edge E0:
  - busy=1 from E0 through E0+DIVIDEND_W (8 edges for the defaults).
  - The final step occurs at edge E0+DIVIDEND_W. After that edge: busy=0, done=1, results valid.
  - Latency: start to done = DIVIDEND_W+1 clock cycles, counted from the start cycle.
- done is high for exactly one cycle.
  - If start=1 in the DONE cycle, it is accepted: back-to-back operation, with no idle gap required.
  - Throughput in that case: one result per DIVIDEND_W+1 cycles.
- Divide-by-zero: done and div_by_zero are asserted the cycle after the accepting edge. busy stays 0.
- busy and done are never high at the same time.

## Structure
- Package div_pkg contains:
  - DIVIDEND_W_DEF and DIVISOR_W_DEF constants.
  - State enum div_state_t {IDLE, RUN, DONE}.
  - Counter width constant CNT_W = $clog2(DIVIDEND_W+1).
- One natural sub-module: divider_step. It is combinational and performs one restoring iteration.
  - Inputs: R, Q, divisor.
  - Outputs: next R, next Q.
  - The top level holds the FSM, counter and registers, and instantiates one divider_step.

## Test plan
- Exact division:
  - dividend=225, divisor=15 → after 9 cycles, done pulse with quotient=15, remainder=0.
  - Then dividend=72, divisor=9 → quotient=8, remainder=0.
- Non-exact and edge operands:
  - 200/7 → quotient=28, remainder=4.
  - 255/1 → quotient=255, remainder=0.
  - 3/10 → quotient=0, remainder=3.
  - 0/5 → quotient=0, remainder=0.
- Divide by zero: 5/0 → done one cycle after start with div_by_zero=1, quotient=255, remainder=0, and busy never asserted.
- Handshake:
  - start pulsed mid-RUN with different operands → ignored; the original result is returned.
  - start held high in the DONE cycle → a second operation begins and its done arrives 9 cycles later.
- Reset: assert rst_n=0 at cycle 4 of RUN → all outputs 0 immediately and no done pulse. After release, 60/6 → quotient=10, remainder=0.
- Exhaustive sweep: all 256×15 nonzero-divisor pairs checked against dividend = quotient×divisor + remainder with remainder < divisor. Results must also hold stable from the done cycle until the next start.

Source files
------------

// File: rtl/divider_8by4_shift_sub_pkg.sv
// Purpose: shared widths, counter sizing and FSM state type for the shift-subtract divider.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: DIVIDEND_W_DEF / DIVISOR_W_DEF default widths, CNT_W step-counter width,
//           div_state_t controller states.
package div_pkg;

  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;

  // Counter must be able to hold the value DIVIDEND_W (one past the last step index).
  localparam int CNT_W = $clog2(DIVIDEND_W_DEF + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/divider_8by4_shift_sub_if.sv
// Purpose: start/busy/done request-result bundle between a requester and the divider.
// Latency: n/a (wires only).
// Backpressure: none; start is ignored by the divider while busy is high.
// Ports: master drives start/dividend/divisor; slave drives busy/done/quotient/remainder/div_by_zero.
interface divider_8by4_shift_sub_if
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
);

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/divider_8by4_shift_sub_step.sv
// Purpose: one combinational restoring-division iteration on the {R,Q} pair.
// Latency: 0 cycles (pure combinational).
// Backpressure: n/a.
// Ports: r_in/q_in current partial remainder and quotient shift register, divisor;
//        r_out/q_out values after shift, trial subtract and quotient-bit insert.
module divider_step
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W:0]    r_in,
  input  logic [DIVIDEND_W-1:0] q_in,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic [DIVISOR_W:0]    r_out,
  output logic [DIVIDEND_W-1:0] q_out
);

  logic [DIVISOR_W:0] r_sh;
  logic [DIVISOR_W:0] dsr_ext;
  logic               ge;

  always_comb begin
    r_sh    = {r_in[DIVISOR_W-1:0], q_in[DIVIDEND_W-1]};
    dsr_ext = {1'b0, divisor};
    // A bit shifted out of R's top means the true shifted value already
    // exceeds any divisor; with R < divisor on entry this never happens,
    // but folding it in keeps the compare exact for any R.
    ge      = r_in[DIVISOR_W] | (r_sh >= dsr_ext);
    r_out   = ge ? (r_sh - dsr_ext) : r_sh;
    q_out   = {q_in[DIVIDEND_W-2:0], ge};
  end

endmodule

// File: rtl/divider_8by4_shift_sub.sv
// Purpose: sequential restoring unsigned divider, DIVIDEND_W / DIVISOR_W -> quotient, remainder.
// Latency: done DIVIDEND_W+1 cycles after the start cycle; divide-by-zero reports done next cycle.
// Backpressure: start accepted only in IDLE or DONE; start while busy is ignored.
// Ports: clk, rst_n (async active-low); div_if.slave carries start/operands in, busy/done/results out.
module divider_8by4_shift_sub
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                      clk,
  input  logic                      rst_n,
  divider_8by4_shift_sub_if.slave   div_if
);

  localparam int CNT_LW = $clog2(DIVIDEND_W + 1);

  div_state_t            state_q, state_d;
  logic [DIVISOR_W:0]    r_q, r_d;
  logic [DIVIDEND_W-1:0] q_q, q_d;
  logic [DIVISOR_W-1:0]  dsr_q, dsr_d;
  logic [CNT_LW-1:0]     cnt_q, cnt_d;
  logic                  dbz_q, dbz_d;

  logic [DIVISOR_W:0]    r_step;
  logic [DIVIDEND_W-1:0] q_step;

  divider_step #(
    .DIVIDEND_W (DIVIDEND_W),
    .DIVISOR_W  (DIVISOR_W)
  ) u_step (
    .r_in    (r_q),
    .q_in    (q_q),
    .divisor (dsr_q),
    .r_out   (r_step),
    .q_out   (q_step)
  );

  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    q_d     = q_q;
    dsr_d   = dsr_q;
    cnt_d   = cnt_q;
    dbz_d   = dbz_q;

    case (state_q)
      IDLE, DONE: begin
        if (div_if.start) begin
          dsr_d = div_if.divisor;
          q_d   = div_if.dividend;
          r_d   = '0;
          cnt_d = '0;
          dbz_d = 1'b0;
          if (div_if.divisor == '0) begin
            // Skip iterating: saturated quotient flags the illegal operation.
            q_d     = '1;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = RUN;
          end
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      RUN: begin
        r_d   = r_step;
        q_d   = q_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_LW'(DIVIDEND_W - 1)) begin
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      q_q     <= '0;
      dsr_q   <= '0;
      cnt_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      r_q     <= r_d;
      q_q     <= q_d;
      dsr_q   <= dsr_d;
      cnt_q   <= cnt_d;
      dbz_q   <= dbz_d;
    end
  end

  // DONE only ever lasts one cycle per result, so done is a pulse by construction.
  assign div_if.busy        = (state_q == RUN);
  assign div_if.done        = (state_q == DONE);
  assign div_if.quotient    = q_q;
  assign div_if.remainder   = r_q[DIVISOR_W-1:0];
  assign div_if.div_by_zero = dbz_q;

endmodule
